// File: rtl/hc165_key_scan_if.sv
// Pin-level and key-level signals between the 74HC165 scanner and its neighbours.
// master = scanner side, slave = shift-register chain / key consumer side.
interface hc165_key_scan_if #(
  parameter int N_BITS = 16
);
  logic              q;
  logic              pl_n;
  logic              cp;
  logic              ce_n;
  logic [N_BITS-1:0] keys;
  logic [N_BITS-1:0] key_press;
  logic              scan_done;

  modport master (
    input  q,
    output pl_n, cp, ce_n, keys, key_press, scan_done
  );

  modport slave (
    output q,
    input  pl_n, cp, ce_n, keys, key_press, scan_done
  );
endinterface

// File: rtl/hc165_key_scan.sv
// Periodic 74HC165 chain reader: load, shift in N_BITS, then debounce the whole
// key vector and emit debounced levels plus one-cycle press pulses.
module hc165_key_scan #(
  parameter int N_BITS      = 16,
  parameter int CLK_DIV     = 4,
  parameter int SCAN_PERIOD = 50000,
  parameter int DEB_CNT     = 20
) (
  input  logic               sclk,
  input  logic               nrst,
  hc165_key_scan_if.master   bus
);

  localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SW = $clog2(DEB_CNT + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] SAMPLE_PT  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] CP_HIGH    = DW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N_BITS - 1);
  localparam logic [SW-1:0] DEB_MAX    = SW'(DEB_CNT);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tickCnt_q, tickCnt_d;
  logic [DW-1:0]      divCnt_q, divCnt_d;
  logic [BW-1:0]      bitCnt_q, bitCnt_d;
  logic [N_BITS-1:0]  sample_q, sample_d;
  logic [N_BITS-1:0]  rawPrev_q, rawPrev_d;
  logic [SW-1:0]      stableCnt_q, stableCnt_d;
  logic [N_BITS-1:0]  keys_q, keys_d;
  logic [N_BITS-1:0]  keyPress_q, keyPress_d;
  logic               scanDone_q, scanDone_d;
  logic               plN_q, plN_d;
  logic               cp_q, cp_d;
  logic               ceN_q, ceN_d;
  logic               tick;

  // Free-running scan period counter; it keeps running during a frame.
  assign tick      = (tickCnt_q == TICK_LAST);
  assign tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      tickCnt_q   <= '0;
      divCnt_q    <= '0;
      bitCnt_q    <= '0;
      sample_q    <= '0;
      rawPrev_q   <= '1;
      stableCnt_q <= '0;
      keys_q      <= '0;
      keyPress_q  <= '0;
      scanDone_q  <= 1'b0;
      plN_q       <= 1'b1;
      cp_q        <= 1'b0;
      ceN_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      divCnt_q    <= divCnt_d;
      bitCnt_q    <= bitCnt_d;
      sample_q    <= sample_d;
      rawPrev_q   <= rawPrev_d;
      stableCnt_q <= stableCnt_d;
      keys_q      <= keys_d;
      keyPress_q  <= keyPress_d;
      scanDone_q  <= scanDone_d;
      plN_q       <= plN_d;
      cp_q        <= cp_d;
      ceN_q       <= ceN_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    divCnt_d    = divCnt_q;
    bitCnt_d    = bitCnt_q;
    sample_d    = sample_q;
    rawPrev_d   = rawPrev_q;
    stableCnt_d = stableCnt_q;
    keys_d      = keys_q;
    keyPress_d  = '0;
    scanDone_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = LOAD;
          divCnt_d = '0;
          bitCnt_d = '0;
        end
      end

      LOAD: begin
        if (divCnt_q == DIV_LAST) begin
          state_d  = SHIFT;
          divCnt_d = '0;
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end

      SHIFT: begin
        // Shifting left puts the first sample (QH = D7 of the last chip) in the MSB.
        if (divCnt_q == SAMPLE_PT) begin
          sample_d = {sample_q[N_BITS-2:0], bus.q};
        end
        if (divCnt_q == DIV_LAST) begin
          divCnt_d = '0;
          if (bitCnt_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end

      DONE: begin
        scanDone_d = 1'b1;
        state_d    = IDLE;
        rawPrev_d  = sample_q;
        if (sample_q == rawPrev_q) begin
          if (stableCnt_q != DEB_MAX) begin
            stableCnt_d = stableCnt_q + 1'b1;
          end
        end else begin
          stableCnt_d = '0;
        end
        // Keys only move on the scan that reaches the debounce threshold.
        if ((stableCnt_q != DEB_MAX) && (stableCnt_d == DEB_MAX)) begin
          keys_d     = ~sample_q;
          keyPress_d = ~sample_q & ~keys_q;
        end
      end

      default: state_d = IDLE;
    endcase

    plN_d = (state_d != LOAD);
    ceN_d = (state_d != SHIFT);
    cp_d  = (state_d == SHIFT) && (divCnt_d >= CP_HIGH);
  end

  assign bus.pl_n      = plN_q;
  assign bus.cp        = cp_q;
  assign bus.ce_n      = ceN_q;
  assign bus.keys      = keys_q;
  assign bus.key_press = keyPress_q;
  assign bus.scan_done = scanDone_q;

endmodule
